trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Multi-cycle machine-mode trap sequencer between the trap dispatch logic and the CSR file / fetch unit.
- On an accepted trap request it serially writes mepc, mcause, mtval and mstatus through a single CSR write port, then redirects fetch to mtvec.
- On MRET it restores mstatus and redirects fetch to mepc.
- Holds the pipeline for the whole sequence so that only one trap or return is in flight at a time.

Parameters:
- XLEN, 32, datapath and PC width.
- MXLEN, 32, CSR width; mcause, mtval and mstatus are this width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_trap_req  in  1  trap request from dispatch; valid only in the cycle it is asserted
- i_trap_cause  in  MXLEN  encoded cause (trap_cause_t value)
- i_trap_tval  in  MXLEN  trap value
- i_pc  in  XLEN  PC of the faulting instruction
- i_mret  in  1  MRET retiring this cycle
- i_mtvec  in  MXLEN  current mtvec
- i_mepc  in  MXLEN  current mepc
- i_mstatus  in  MXLEN  current mstatus
- o_csr_we  out  1  CSR write strobe
- o_csr_addr  out  12  CSR write address
- o_csr_wdata  out  MXLEN  CSR write data
- o_stall  out  1  hold fetch/decode/execute
- o_flush  out  1  kill in-flight instructions
- o_redirect  out  1  load o_redirect_pc into the PC
- o_redirect_pc  out  XLEN  new PC
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset is asynchronous and active-high:
  - state goes to IDLE;
  - all outputs and latched registers clear to 0;
  - asserting reset mid-sequence abandons it, and no further CSR writes occur.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_REDIR, R_STATUS, R_REDIR.
- In IDLE:
  - i_trap_req=1: latch pc, cause and tval; go to T_EPC; assert o_flush this cycle (combinational).
  - else i_mret=1: go to R_STATUS; assert o_flush.
  - Trap has priority over MRET in the same cycle; the MRET is dropped.
- Trap write sequence, one write per state with o_csr_we=1:
  - T_EPC: addr 0x341, data = latched pc with bits[1:0] cleared.
  - T_CAUSE: addr 0x342, data = latched cause.
  - T_TVAL: addr 0x343, data = latched tval.
  - T_STATUS: addr 0x300, data = i_mstatus with MPIE(bit7) = MIE(bit3), MIE = 0, MPP(bits12:11) = 2'b11; all other bits unchanged.
- T_REDIR:
  - o_redirect=1, o_redirect_pc = {i_mtvec[XLEN-1:2], 2'b00}.
  - Direct mode is used even if mtvec.MODE=1, because only synchronous exceptions exist.
  - Next state IDLE.
- R_STATUS:
  - Writes addr 0x300, data = i_mstatus with MIE = MPIE, MPIE = 1, MPP = 2'b11.
- R_REDIR:
  - o_redirect=1, o_redirect_pc = {i_mepc[XLEN-1:2], 2'b00}; next state IDLE.
- Latency:
  - Trap: req in cycle 0, writes in cycles 1–4, redirect in cycle 5.
  - MRET: mret in cycle 0, write in cycle 1, redirect in cycle 2.
- o_stall = (state != IDLE) | i_trap_req | i_mret (combinational), so the pipeline freezes in the request cycle.
- o_stall deasserts in the cycle after the redirect.
- o_busy = (state != IDLE), registered-state decode.
- Requests while busy:
  - i_trap_req and i_mret while not in IDLE are ignored.
  - They are not queued; upstream is stalled, so none are expected.
- CSR write data is sampled from i_mstatus in the writing state, so it reflects any earlier write in the same sequence.
- Outside write states: o_csr_we=0, o_csr_addr=0, o_csr_wdata=0.
- Outside redirect states: o_redirect=0, o_redirect_pc=0.

Test Plan:
- Illegal instruction:
  - Stimulus: pc=0x0000_0104, cause=2, tval=0x0000_FFFF, mtvec=0x0000_0200, mstatus=0x0000_0008.
  - Response: writes 0x341←0x104, 0x342←2, 0x343←0xFFFF, 0x300←0x0000_1880 in cycles 1–4; redirect to 0x200 in cycle 5; o_stall high in cycles 0–5.
- MRET:
  - Stimulus: mepc=0x0000_0108, mstatus=0x0000_1880.
  - Response: 0x300←0x0000_1888 in cycle 1; redirect to 0x108 in cycle 2; o_busy low in cycle 3.
- Vectored mtvec:
  - Stimulus: mtvec=0x0000_0201, ecall (cause 11).
  - Response: redirect_pc=0x0000_0200; mtval write = 0.
- Simultaneous i_trap_req and i_mret in IDLE:
  - Response: trap sequence only; no R_STATUS write occurs.
- Extra trap while busy:
  - Stimulus: second i_trap_req pulse at T_CAUSE.
  - Response: ignored; exactly 4 CSR writes and 1 redirect.
- Reset during T_TVAL:
  - Stimulus: assert i_rst asynchronously.
  - Response: all outputs go to 0 immediately; IDLE after release; no mstatus write observed.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Trap sequencer bus: dispatch/CSR/fetch side signals.
// master drives requests and CSR state; slave is the sequencer.
interface trap_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int MXLEN = 32
);
    logic             i_trap_req;
    logic [MXLEN-1:0] i_trap_cause;
    logic [MXLEN-1:0] i_trap_tval;
    logic [XLEN-1:0]  i_pc;
    logic             i_mret;
    logic [MXLEN-1:0] i_mtvec;
    logic [MXLEN-1:0] i_mepc;
    logic [MXLEN-1:0] i_mstatus;
    logic             o_csr_we;
    logic [11:0]      o_csr_addr;
    logic [MXLEN-1:0] o_csr_wdata;
    logic             o_stall;
    logic             o_flush;
    logic             o_redirect;
    logic [XLEN-1:0]  o_redirect_pc;
    logic             o_busy;

    modport master (
        output i_trap_req, i_trap_cause, i_trap_tval, i_pc,
        output i_mret, i_mtvec, i_mepc, i_mstatus,
        input  o_csr_we, o_csr_addr, o_csr_wdata,
        input  o_stall, o_flush, o_redirect, o_redirect_pc, o_busy
    );

    modport slave (
        input  i_trap_req, i_trap_cause, i_trap_tval, i_pc,
        input  i_mret, i_mtvec, i_mepc, i_mstatus,
        output o_csr_we, o_csr_addr, o_csr_wdata,
        output o_stall, o_flush, o_redirect, o_redirect_pc, o_busy
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer: serial CSR writes
// through one write port, then a fetch redirect.
module trap_ctrl #(
    parameter int XLEN  = 32,
    parameter int MXLEN = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    trap_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STATUS,
        T_REDIR,
        R_STATUS,
        R_REDIR
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [XLEN-1:0]  pc_q;
    logic [MXLEN-1:0] cause_q;
    logic [MXLEN-1:0] tval_q;
    logic [MXLEN-1:0] st_trap;
    logic [MXLEN-1:0] st_ret;

    // State register and trap context captured on acceptance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.i_trap_req) begin
                pc_q    <= bus.i_pc;
                cause_q <= bus.i_trap_cause;
                tval_q  <= bus.i_trap_tval;
            end
        end
    end

    // mstatus images for trap entry and return.
    always_comb begin
        st_trap        = bus.i_mstatus;
        st_trap[7]     = bus.i_mstatus[3];
        st_trap[3]     = 1'b0;
        st_trap[12:11] = 2'b11;
        st_ret         = bus.i_mstatus;
        st_ret[3]      = bus.i_mstatus[7];
        st_ret[7]      = 1'b1;
        st_ret[12:11]  = 2'b11;
    end

    // Next state and per-state CSR write / redirect outputs.
    always_comb begin
        state_d           = state_q;
        bus.o_csr_we      = 1'b0;
        bus.o_csr_addr    = '0;
        bus.o_csr_wdata   = '0;
        bus.o_flush       = 1'b0;
        bus.o_redirect    = 1'b0;
        bus.o_redirect_pc = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_trap_req) begin
                    state_d     = T_EPC;
                    bus.o_flush = 1'b1;
                end else if (bus.i_mret) begin
                    state_d     = R_STATUS;
                    bus.o_flush = 1'b1;
                end
            end
            T_EPC: begin
                bus.o_csr_we    = 1'b1;
                bus.o_csr_addr  = 12'h341;
                bus.o_csr_wdata = MXLEN'(pc_q & ~XLEN'(3));
                state_d         = T_CAUSE;
            end
            T_CAUSE: begin
                bus.o_csr_we    = 1'b1;
                bus.o_csr_addr  = 12'h342;
                bus.o_csr_wdata = cause_q;
                state_d         = T_TVAL;
            end
            T_TVAL: begin
                bus.o_csr_we    = 1'b1;
                bus.o_csr_addr  = 12'h343;
                bus.o_csr_wdata = tval_q;
                state_d         = T_STATUS;
            end
            T_STATUS: begin
                bus.o_csr_we    = 1'b1;
                bus.o_csr_addr  = 12'h300;
                bus.o_csr_wdata = st_trap;
                state_d         = T_REDIR;
            end
            T_REDIR: begin
                // Only synchronous exceptions: always direct mode.
                bus.o_redirect    = 1'b1;
                bus.o_redirect_pc = XLEN'(bus.i_mtvec & ~MXLEN'(3));
                state_d           = IDLE;
            end
            R_STATUS: begin
                bus.o_csr_we    = 1'b1;
                bus.o_csr_addr  = 12'h300;
                bus.o_csr_wdata = st_ret;
                state_d         = R_REDIR;
            end
            R_REDIR: begin
                bus.o_redirect    = 1'b1;
                bus.o_redirect_pc = XLEN'(bus.i_mepc & ~MXLEN'(3));
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_rst) begin
            bus.o_flush = 1'b0;
        end
    end

    // Pipeline hold covers the request cycle and the whole sequence.
    always_comb begin
        bus.o_busy  = (state_q != IDLE);
        bus.o_stall = ~i_rst &
                      ((state_q != IDLE) | bus.i_trap_req | bus.i_mret);
    end
endmodule
